// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler that splits 0..7 shift amounts into
// passes of at most 3 through a shared 4-bit barrel shifter (2-bit amount).
module shift_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_data,
  input  logic [2:0] req0_amt,
  input  logic       req0_dir,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_data,
  input  logic [2:0] req1_amt,
  input  logic       req1_dir,
  output logic [3:0] bs_data_in,
  output logic [1:0] bs_shift_amt,
  output logic       bs_dir,
  input  logic [3:0] bs_data_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t     state;
  logic [3:0] work;
  logic [2:0] rem;
  logic       dir_q;
  logic       id_q;
  logic       last_grant;

  logic       gnt;
  logic       in_idle;
  logic [3:0] sel_data;
  logic [2:0] sel_amt;
  logic       sel_dir;
  logic [1:0] step;

  // On a tie, favour the requester that was not served last.
  assign gnt      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign sel_data = gnt ? req1_data : req0_data;
  assign sel_amt  = gnt ? req1_amt  : req0_amt;
  assign sel_dir  = gnt ? req1_dir  : req0_dir;
  assign step     = (rem > 3'd3) ? 2'd3 : rem[1:0];

  // Reset forces every output quiet even while the state register still
  // holds its pre-reset value.
  assign in_idle      = (state == IDLE) & ~rst;
  assign req0_ready   = in_idle & req0_valid & ~gnt;
  assign req1_ready   = in_idle & req1_valid &  gnt;
  assign bs_data_in   = rst ? 4'd0 : work;
  assign bs_shift_amt = (state == SHIFT && !rst) ? step  : 2'd0;
  assign bs_dir       = (state == SHIFT && !rst) ? dir_q : 1'b0;
  assign rsp_valid    = (state == RESP) & ~rst;
  assign rsp_data     = rsp_valid ? work : 4'd0;
  assign rsp_id       = rsp_valid ? id_q : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      work       <= 4'd0;
      rem        <= 3'd0;
      dir_q      <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            work       <= sel_data;
            rem        <= sel_amt;
            dir_q      <= sel_dir;
            id_q       <= gnt;
            last_grant <= gnt;
            busy       <= 1'b1;
            state      <= (sel_amt != 3'd0) ? SHIFT : RESP;
          end
        end
        SHIFT: begin
          work <= bs_data_out;
          rem  <= rem - {1'b0, step};
          if (rem == {1'b0, step}) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_dir;
  logic [3:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [3:0] req1_data;
  logic [2:0] req1_amt;
  logic [3:0] bs_data_in, bs_data_out;
  logic [1:0] bs_shift_amt;
  logic       bs_dir;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_data;

  int checks = 0;
  int failures = 0;
  bit model_last;
  int lat_o;
  int steps_q[$];
  bit acc_ok;
  bit rdy_bad;

  always #5 clk = ~clk;

  function automatic logic [3:0] rot(input logic [3:0] d, input int n, input logic dr);
    logic [3:0] r;
    r = d;
    for (int i = 0; i < n % 4; i++) r = dr ? {r[0], r[3:1]} : {r[2:0], r[3]};
    return r;
  endfunction

  function automatic int exp_step(input int a, input int i);
    return (a - 3 * i > 3) ? 3 : a - 3 * i;
  endfunction

  assign bs_data_out = rot(bs_data_in, int'(bs_shift_amt), bs_dir);

  shift_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .bs_data_in(bs_data_in), .bs_shift_amt(bs_shift_amt), .bs_dir(bs_dir),
    .bs_data_out(bs_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input bit who, input logic [3:0] d, input logic [2:0] a,
                         input logic dr, input bit wiggle);
    int k;
    steps_q.delete();
    rdy_bad = 0;
    acc_ok  = 0;
    lat_o   = -1;
    if (!who) begin
      req0_valid = 1; req0_data = d; req0_amt = a; req0_dir = dr;
    end else begin
      req1_valid = 1; req1_data = d; req1_amt = a; req1_dir = dr;
    end
    #1;
    for (int i = 0; i < 20 && !acc_ok; i++) begin
      if (who ? req1_ready : req0_ready) acc_ok = 1;
      else tick();
    end
    if (who ? req0_ready : req1_ready) rdy_bad = 1;
    tick();
    model_last = who;
    req0_valid = 0;
    req1_valid = 0;
    k = 1;
    while (!rsp_valid && k < 20) begin
      steps_q.push_back(int'(bs_shift_amt));
      if (req0_ready || req1_ready) rdy_bad = 1;
      if (wiggle) begin
        if (who) begin
          req1_valid = 1; req1_data = 4'($urandom); req1_amt = 3'($urandom); req1_dir = 1'($urandom);
        end else begin
          req0_valid = 1; req0_data = 4'($urandom); req0_amt = 3'($urandom); req0_dir = 1'($urandom);
        end
      end
      tick();
      k++;
    end
    req0_valid = 0;
    req1_valid = 0;
    if (rsp_valid) lat_o = k;
  endtask

  task automatic consume;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    req0_valid = 1; req0_data = 4'hF; req0_amt = 3'd5; req0_dir = 0;
    req1_valid = 1; req1_data = 4'hA; req1_amt = 3'd2; req1_dir = 1;
    tick(); tick();
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl: r0=%b r1=%b rv=%b busy=%b want 0", req0_ready, req1_ready, rsp_valid, busy);
    end
    checks++;
    if ({rsp_data, rsp_id, bs_data_in, bs_shift_amt, bs_dir} !== 12'b0) begin
      failures++;
      $display("FAIL reset_data: rd=%h rid=%b bsd=%h bsa=%0d bsdir=%b want 0",
               rsp_data, rsp_id, bs_data_in, bs_shift_amt, bs_dir);
    end
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    model_last = 1;
    tick();
  endtask

  task automatic test_reset_mid_job;
    bit got;
    got = 0;
    req0_valid = 1; req0_data = 4'($urandom); req0_amt = 3'd7; req0_dir = 1'($urandom);
    #1;
    for (int i = 0; i < 20 && !got; i++) if (req0_ready) got = 1; else tick();
    tick();
    req0_valid = 0;
    tick();
    rst = 1;
    #1;
    checks++;
    if (!got || bs_shift_amt !== 2'd0 || bs_data_in !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: acc=%b bsa=%0d bsd=%h want acc=1 bsa=0 bsd=0", got, bs_shift_amt, bs_data_in);
    end
    tick();
    rst = 0;
    model_last = 1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle: busy=%b rv=%b want 0 0", busy, rsp_valid);
    end
    got = 0;
    repeat (4) begin
      if (rsp_valid || busy) got = 1;
      tick();
    end
    checks++;
    if (got) begin
      failures++;
      $display("FAIL rst_mid_noresp: response or busy seen after reset");
    end
    run_job(0, 4'b0001, 3'd7, 0, 0);
    checks++;
    if (!acc_ok || lat_o !== 4) begin
      failures++;
      $display("FAIL seven_lat: acc=%b lat=%0d want 1 4", acc_ok, lat_o);
    end
    checks++;
    if (steps_q.size() != 3 || steps_q[0] != 3 || steps_q[1] != 3 || steps_q[2] != 1) begin
      failures++;
      $display("FAIL seven_steps: got %p want 3,3,1", steps_q);
    end
    checks++;
    if (rsp_data !== 4'b1000 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL seven_rsp: data=%b id=%b want 1000 0", rsp_data, rsp_id);
    end
    consume();
  endtask

  task automatic test_zero_amt;
    run_job(1, 4'b1010, 3'd0, 0, 0);
    checks++;
    if (!acc_ok || lat_o !== 1 || steps_q.size() != 0) begin
      failures++;
      $display("FAIL zero_lat: acc=%b lat=%0d passes=%0d want 1 1 0", acc_ok, lat_o, steps_q.size());
    end
    checks++;
    if (rsp_data !== 4'b1010 || rsp_id !== 1'b1 || bs_shift_amt !== 2'd0) begin
      failures++;
      $display("FAIL zero_rsp: data=%b id=%b bsa=%0d want 1010 1 0", rsp_data, rsp_id, bs_shift_amt);
    end
    consume();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_release: busy=%b rv=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_two_pass;
    run_job(0, 4'b1001, 3'd5, 0, 0);
    checks++;
    if (lat_o !== 3 || steps_q.size() != 2 || steps_q[0] != 3 || steps_q[1] != 2) begin
      failures++;
      $display("FAIL five_steps: lat=%0d steps=%p want 3 and 3,2", lat_o, steps_q);
    end
    checks++;
    if (rsp_data !== 4'b0011 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL five_rsp: data=%b id=%b want 0011 0", rsp_data, rsp_id);
    end
    consume();
    run_job(0, 4'b0110, 3'd2, 1, 0);
    checks++;
    if (lat_o !== 2 || steps_q.size() != 1 || rsp_data !== 4'b1001) begin
      failures++;
      $display("FAIL two_rsp: lat=%0d passes=%0d data=%b want 2 1 1001", lat_o, steps_q.size(), rsp_data);
    end
    consume();
  endtask

  task automatic test_round_robin;
    int n0, n1, k;
    bit got, g, exp_g, bad;
    logic [3:0] ed;
    n0 = 0; n1 = 0;
    rst = 1; tick(); rst = 0;
    model_last = 1;
    req0_data = 4'($urandom); req0_amt = 3'($urandom); req0_dir = 1'($urandom);
    req1_data = 4'($urandom); req1_amt = 3'($urandom); req1_dir = 1'($urandom);
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int j = 0; j < 6; j++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) if (req0_ready || req1_ready) got = 1; else tick();
      exp_g = (req0_valid && req1_valid) ? !model_last : req1_valid;
      checks++;
      if (!got || (req0_ready && req1_ready) || req1_ready !== exp_g) begin
        failures++;
        $display("FAIL rr_grant: job=%0d r0=%b r1=%b want r1=%b", j, req0_ready, req1_ready, exp_g);
      end
      g  = req1_ready;
      ed = g ? rot(req1_data, int'(req1_amt), req1_dir) : rot(req0_data, int'(req0_amt), req0_dir);
      tick();
      model_last = g;
      if (g) begin
        n1++;
        if (n1 == 3) req1_valid = 0;
        else begin req1_data = 4'($urandom); req1_amt = 3'($urandom); req1_dir = 1'($urandom); end
      end else begin
        n0++;
        if (n0 == 3) req0_valid = 0;
        else begin req0_data = 4'($urandom); req0_amt = 3'($urandom); req0_dir = 1'($urandom); end
      end
      k = 0; bad = 0;
      while (!rsp_valid && k < 20) begin
        if (req0_ready || req1_ready) bad = 1;
        tick(); k++;
      end
      checks++;
      if (!rsp_valid || bad || rsp_id !== g || rsp_data !== ed) begin
        failures++;
        $display("FAIL rr_rsp: job=%0d rv=%b rdy_leak=%b id=%b data=%h want id=%b data=%h",
                 j, rsp_valid, bad, rsp_id, rsp_data, g, ed);
      end
      consume();
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] d, ed, ed1;
    logic [2:0] a;
    logic dr;
    int k;
    d = 4'($urandom); a = 3'($urandom_range(1, 7)); dr = 1'($urandom);
    ed = rot(d, int'(a), dr);
    run_job(0, d, a, dr, 0);
    req1_valid = 1; req1_data = 4'($urandom); req1_amt = 3'd2; req1_dir = 1'($urandom);
    ed1 = rot(req1_data, 2, req1_dir);
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_id !== 1'b0 || req0_ready || req1_ready) begin
        failures++;
        $display("FAIL bp_hold: cyc=%0d rv=%b data=%h id=%b r0=%b r1=%b want 1 %h 0 0 0",
                 c, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, ed);
      end
      tick();
    end
    consume();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: busy=%b rv=%b r1=%b want 0 0 1", busy, rsp_valid, req1_ready);
    end
    tick();
    model_last = 1;
    req1_valid = 0;
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    checks++;
    if (!rsp_valid || rsp_data !== ed1 || rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL bp_next: rv=%b data=%h id=%b want 1 %h 1", rsp_valid, rsp_data, rsp_id, ed1);
    end
    consume();
  endtask

  task automatic test_req_change;
    logic [3:0] d;
    logic dr;
    d = 4'($urandom); dr = 1'($urandom);
    run_job(1, d, 3'd6, dr, 1);
    checks++;
    if (!acc_ok || rdy_bad || lat_o !== 3 || rsp_data !== rot(d, 6, dr) || rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL req_change: acc=%b leak=%b lat=%0d data=%h id=%b want 1 0 3 %h 1",
               acc_ok, rdy_bad, lat_o, rsp_data, rsp_id, rot(d, 6, dr));
    end
    consume();
  endtask

  task automatic test_random;
    bit who, dr, bad;
    logic [3:0] d, snap;
    logic [2:0] a;
    int np, stall;
    for (int n = 0; n < 24; n++) begin
      who = 1'($urandom); d = 4'($urandom); a = 3'($urandom); dr = 1'($urandom);
      stall = $urandom_range(0, 3);
      np = (int'(a) + 2) / 3;
      run_job(who, d, a, dr, 1'($urandom));
      bad = (steps_q.size() != np);
      for (int i = 0; i < steps_q.size() && i < np; i++) if (steps_q[i] != exp_step(int'(a), i)) bad = 1;
      checks++;
      if (!acc_ok || rdy_bad || bad || lat_o !== 1 + np) begin
        failures++;
        $display("FAIL rand_timing: n=%0d amt=%0d acc=%b leak=%b lat=%0d steps=%p want lat=%0d",
                 n, a, acc_ok, rdy_bad, lat_o, steps_q, 1 + np);
      end
      snap = rsp_data;
      repeat (stall) begin
        tick();
        if (rsp_data !== snap || !rsp_valid) bad = 1;
      end
      checks++;
      if (bad || rsp_data !== rot(d, int'(a), dr) || rsp_id !== who) begin
        failures++;
        $display("FAIL rand_rsp: n=%0d data=%h id=%b want %h %b", n, rsp_data, rsp_id, rot(d, int'(a), dr), who);
      end
      consume();
    end
  endtask

  initial begin
    rst = 1; rsp_ready = 0;
    req0_valid = 0; req0_data = 0; req0_amt = 0; req0_dir = 0;
    req1_valid = 0; req1_data = 0; req1_amt = 0; req1_dir = 0;
    model_last = 1;
    test_reset();
    test_reset_mid_job();
    test_zero_amt();
    test_two_pass();
    test_round_robin();
    test_backpressure();
    test_req_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
